// File: rtl/state_ser_pkg.sv
// Constants and state encoding shared by the state word serializer and its FIFO.
package state_ser_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; dout always shows the head entry, full/empty derive from the level count.
module sync_fifo
  import state_ser_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LvlW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  // Push is refused while full even if a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/state_word_serializer.sv
// Buffers captured state words and shifts them out one bit per ser_en strobe,
// flagging the first bit of each word and counting completed words.
module state_word_serializer
  import state_ser_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  input  logic                          ser_en,
  output logic                          ser_data,
  output logic                          ser_valid,
  output logic                          ser_sof,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   words_sent
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0]      words_q, words_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic             bit_last;
  logic             out_bit;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid & in_ready),
    .din   (in_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign in_ready   = ~fifo_full;
  assign bit_last   = (bit_cnt_q == CntW'(WIDTH - 1));
  assign out_bit    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign ser_valid  = (state_q == StShift);
  assign ser_data   = ser_valid & out_bit;
  assign ser_sof    = ser_valid & (bit_cnt_q == '0);
  assign words_sent = words_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    words_d   = words_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shreg_d   = fifo_dout;
          bit_cnt_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (ser_en) begin
          if (bit_last) begin
            words_d = words_q + 16'd1;
            // Reload straight from the FIFO so consecutive words have no gap cycle.
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              shreg_d   = fifo_dout;
              bit_cnt_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      words_q   <= words_d;
    end
  end

endmodule

// File: tb/tb_state_word_serializer.sv
// Scoreboard bench: expected bits are queued when a word is accepted and compared as they shift out.
module tb_state_word_serializer;

  typedef struct packed {
    logic d;
    logic sof;
    logic last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  // MSB-first instance
  logic        in_valid, in_ready, ser_en, ser_data, ser_valid, ser_sof;
  logic [15:0] in_data, words_sent;
  logic [2:0]  fifo_level;
  // LSB-first instance
  logic        l_in_valid, l_in_ready, l_ser_en, l_ser_data, l_ser_valid, l_ser_sof;
  logic [15:0] l_in_data, l_words_sent;
  logic [2:0]  l_fifo_level;

  exp_t q_m[$];
  exp_t q_l[$];
  exp_t e_m, e_l;
  int   ws_m = 0;
  int   ws_l = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  state_word_serializer #(.WIDTH(16), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ser_en     (ser_en),
    .ser_data   (ser_data),
    .ser_valid  (ser_valid),
    .ser_sof    (ser_sof),
    .fifo_level (fifo_level),
    .words_sent (words_sent)
  );

  state_word_serializer #(.WIDTH(16), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (l_in_valid),
    .in_data    (l_in_data),
    .in_ready   (l_in_ready),
    .ser_en     (l_ser_en),
    .ser_data   (l_ser_data),
    .ser_valid  (l_ser_valid),
    .ser_sof    (l_ser_sof),
    .fifo_level (l_fifo_level),
    .words_sent (l_words_sent)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic enqueue(input bit lsb, input logic [15:0] w);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.d    = lsb ? w[i] : w[15-i];
      e.sof  = (i == 0);
      e.last = (i == 15);
      if (lsb) q_l.push_back(e);
      else     q_m.push_back(e);
    end
  endtask

  // Holds valid until the word is accepted; returns #1 after the accepting edge.
  task automatic push_word(input bit lsb, input logic [15:0] w);
    logic rdy;
    bit   accepted = 1'b0;
    if (lsb) begin l_in_valid = 1'b1; l_in_data = w; end
    else     begin in_valid = 1'b1;   in_data = w;   end
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      rdy = lsb ? l_in_ready : in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        enqueue(lsb, w);
        accepted = 1'b1;
      end
    end
    if (lsb) l_in_valid = 1'b0;
    else     in_valid = 1'b0;
    if (!accepted) check_eq("push_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic drain(input bit lsb, input int max_cycles);
    int left = max_cycles;
    while ((lsb ? q_l.size() : q_m.size()) > 0 && left > 0) begin
      @(posedge clk);
      #1;
      left--;
    end
    if (left == 0) check_eq("drain_timeout", 32'(lsb ? q_l.size() : q_m.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ser_valid) begin
        if (q_m.size() == 0) begin
          check_eq("m_unexpected_bit", 32'(q_m.size()), 32'd1);
        end else begin
          e_m = q_m[0];
          check_eq("m_data", 32'(ser_data), 32'(e_m.d));
          check_eq("m_sof", 32'(ser_sof), 32'(e_m.sof));
          if (ser_en) begin
            void'(q_m.pop_front());
            if (e_m.last) ws_m++;
          end
        end
      end else begin
        check_eq("m_idle_out", 32'({ser_data, ser_sof}), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && l_ser_valid) begin
      if (q_l.size() == 0) begin
        check_eq("l_unexpected_bit", 32'(q_l.size()), 32'd1);
      end else begin
        e_l = q_l[0];
        check_eq("l_data", 32'(l_ser_data), 32'(e_l.d));
        check_eq("l_sof", 32'(l_ser_sof), 32'(e_l.sof));
        if (l_ser_en) begin
          void'(q_l.pop_front());
          if (e_l.last) ws_l++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps;
    int cyc;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF; ser_en = 1'b0;
    l_in_valid = 1'b0; l_in_data = 16'h0; l_ser_en = 1'b0;

    // Reset held 3 cycles with in_valid asserted
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_ser_valid", 32'(ser_valid), 32'd0);
    check_eq("rst_ser_data_sof", 32'({ser_data, ser_sof}), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_words", 32'(words_sent), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Single word, constant strobe, with pop latency
    ser_en = 1'b1;
    push_word(1'b0, 16'hD6A5);
    check_eq("lat_level_after_push", 32'(fifo_level), 32'd1);
    check_eq("lat_idle_after_push", 32'(ser_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("lat_valid_after_pop", 32'(ser_valid), 32'd1);
    check_eq("lat_sof_first_bit", 32'(ser_sof), 32'd1);
    check_eq("lat_level_after_pop", 32'(fifo_level), 32'd0);
    drain(1'b0, 40);
    check_eq("single_idle", 32'(ser_valid), 32'd0);
    check_eq("single_words", 32'(words_sent), 32'd1);

    // Back-to-back words, no gap between them
    push_word(1'b0, 16'hD6A5);
    push_word(1'b0, 16'h0000);
    push_word(1'b0, 16'hFFFF);
    gaps = 0;
    for (int i = 0; i < 80 && q_m.size() > 0; i++) begin
      @(negedge clk);
      if (!ser_valid && q_m.size() > 0) gaps++;
    end
    drain(1'b0, 10);
    check_eq("b2b_gaps", 32'(gaps), 32'd0);
    @(posedge clk); #1;
    check_eq("b2b_words", 32'(words_sent), 32'd4);
    check_eq("b2b_words_model", 32'(words_sent), 32'(ws_m));

    // Backpressure: full FIFO refuses words until the next pop
    ser_en = 1'b0;
    push_word(1'b0, 16'h1111);
    push_word(1'b0, 16'h2222);
    push_word(1'b0, 16'h3C3C);
    push_word(1'b0, 16'hF00F);
    push_word(1'b0, 16'h0F0F);
    check_eq("bp_level_full", 32'(fifo_level), 32'd4);
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 16'h5A5A;
    repeat (4) @(posedge clk);
    #1;
    check_eq("bp_level_held", 32'(fifo_level), 32'd4);
    ser_en = 1'b1;
    push_word(1'b0, 16'h5A5A);
    check_eq("bp_level_refill", 32'(fifo_level), 32'd4);
    drain(1'b0, 200);
    check_eq("bp_words", 32'(words_sent), 32'(ws_m));

    // Throttled strobe: one advance every third cycle
    ser_en = 1'b0;
    push_word(1'b0, 16'h8001);
    cyc = 0;
    while (q_m.size() > 0 && cyc < 200) begin
      ser_en = (cyc % 3 == 2);
      @(posedge clk); #1;
      cyc++;
    end
    ser_en = 1'b0;
    check_eq("thr_drained", 32'(q_m.size()), 32'd0);
    check_eq("thr_cycles", 32'(cyc), 32'd48);
    check_eq("thr_idle", 32'(ser_valid), 32'd0);

    // Reset mid-word with two words queued
    push_word(1'b0, 16'hD6A5);
    push_word(1'b0, 16'h0F0F);
    push_word(1'b0, 16'hF0F0);
    check_eq("mid_level", 32'(fifo_level), 32'd2);
    ser_en = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0; ser_en = 1'b0;
    q_m.delete(); ws_m = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("mid_rst_valid", 32'(ser_valid), 32'd0);
    check_eq("mid_rst_level", 32'(fifo_level), 32'd0);
    check_eq("mid_rst_words", 32'(words_sent), 32'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
    ser_en = 1'b1;
    push_word(1'b0, 16'h1234);
    drain(1'b0, 40);
    check_eq("mid_after_words", 32'(words_sent), 32'd1);

    // LSB-first instance
    l_ser_en = 1'b1;
    push_word(1'b1, 16'h0001);
    push_word(1'b1, 16'hD6A5);
    drain(1'b1, 80);
    check_eq("lsb_idle", 32'(l_ser_valid), 32'd0);
    check_eq("lsb_words", 32'(l_words_sent), 32'd2);
    check_eq("lsb_words_model", 32'(l_words_sent), 32'(ws_l));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
